// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result, aligns/extends load data, and holds
// SRAM read data across stalls so a stalled load writes back the right value.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_load,
  input  logic [2:0]  mem_load_op,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] data_sram_rdata,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;

  logic          valid;
  logic [DW-1:0] pc;
  logic          wreg;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          load;
  logic [2:0]    load_op;
  logic [1:0]    addr_lo;
  logic          first;
  logic          hold_valid;
  logic [DW-1:0] hold;

  logic [DW-1:0] load_src;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_data;

  // WB register: rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid      <= 1'b0;
      pc         <= rst ? RESET_PC : '0;
      wreg       <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      load       <= 1'b0;
      load_op    <= '0;
      addr_lo    <= '0;
      first      <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (stall) begin
      first <= 1'b0;
      // Catch the SRAM data on the only cycle it is guaranteed valid
      if (first) begin
        hold       <= data_sram_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      valid      <= mem_valid;
      pc         <= mem_pc;
      wreg       <= mem_wreg;
      waddr      <= mem_waddr;
      wdata      <= mem_wdata;
      load       <= mem_load;
      load_op    <= mem_load_op;
      addr_lo    <= mem_addr_lo;
      first      <= 1'b1;
      hold_valid <= 1'b0;
    end
  end

  // Load alignment and extension; half-word ignores addr_lo[0]
  always_comb begin
    load_src  = hold_valid ? hold : data_sram_rdata;
    byte_sel  = load_src[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? load_src[31:16] : load_src[15:0];
    load_data = load_src;
    case (load_op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = load_src;
    endcase
  end

  assign wb_wreg           = valid & wreg;
  assign wb_waddr          = waddr;
  assign wb_wdata          = load ? load_data : wdata;
  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{wb_wreg}};
  assign debug_wb_rf_wnum  = waddr;
  assign debug_wb_rf_wdata = wb_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan cases plus randomized
// traffic compared against a transaction-level reference model.
module tb_wb_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_load;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;
  logic [31:0] data_sram_rdata;
  logic        wb_wreg;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_wreg(mem_wreg),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_load(mem_load),
    .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
    .data_sram_rdata(data_sram_rdata),
    .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the instruction sitting in WB, how many edges it has been
  // stalled, and the SRAM word seen during its first WB cycle.
  logic        m_valid, m_wreg, m_load;
  logic [31:0] m_pc, m_wdata, m_first_rdata;
  logic [4:0]  m_waddr;
  logic [2:0]  m_op;
  logic [1:0]  m_lo;
  int          m_age;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] d);
    int unsigned b, h;
    b = (d / (32'd1 << (8 * lo))) % 256;
    h = lo[1] ? d / 65536 : d % 65536;
    case (op)
      3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd1:    return 32'(b);
      3'd2:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd3:    return 32'(h);
      default: return d;
    endcase
  endfunction

  task automatic check_all();
    logic [31:0] src, exp_data;
    logic        exp_we;
    src      = (m_age == 0) ? data_sram_rdata : m_first_rdata;
    exp_data = m_load ? model_load(m_op, m_lo, src) : m_wdata;
    exp_we   = m_valid & m_wreg;
    check_eq("wb_wreg", 32'(wb_wreg), 32'(exp_we));
    check_eq("wb_waddr", 32'(wb_waddr), 32'(m_waddr));
    check_eq("wb_wdata", wb_wdata, exp_data);
    check_eq("debug_pc", debug_wb_pc, m_pc);
    check_eq("rf_wen", 32'(debug_wb_rf_wen), exp_we ? 32'hF : 32'h0);
    check_eq("rf_wnum", 32'(debug_wb_rf_wnum), 32'(m_waddr));
    check_eq("rf_wdata", debug_wb_rf_wdata, exp_data);
  endtask

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      m_valid = 0; m_wreg = 0; m_load = 0; m_wdata = 0; m_waddr = 0;
      m_op = 0; m_lo = 0; m_age = 1;
      m_pc = rst ? RESET_PC : 32'h0;
    end else if (stall) begin
      if (m_age == 0) m_first_rdata = data_sram_rdata;
      m_age++;
    end else begin
      m_valid = mem_valid; m_pc = mem_pc; m_wreg = mem_wreg; m_waddr = mem_waddr;
      m_wdata = mem_wdata; m_load = mem_load; m_op = mem_load_op; m_lo = mem_addr_lo;
      m_age = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive_mem(input logic v, input logic [31:0] pc, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd, input logic ld,
                           input logic [2:0] op, input logic [1:0] lo);
    mem_valid = v; mem_pc = pc; mem_wreg = we; mem_waddr = wa;
    mem_wdata = wd; mem_load = ld; mem_load_op = op; mem_addr_lo = lo;
  endtask

  logic [2:0]  al_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [1:0]  al_lo  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] al_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    m_valid = 0; m_wreg = 0; m_load = 0; m_wdata = 0; m_waddr = 0;
    m_op = 0; m_lo = 0; m_age = 1; m_pc = RESET_PC; m_first_rdata = 0;
    rst = 1; stall = 0; flush = 0; data_sram_rdata = 0;
    drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick(); tick();
    rst = 0;
    #1;
    check_eq("reset_wreg", 32'(wb_wreg), 32'h0);
    check_eq("reset_pc", debug_wb_pc, 32'hBFC0_0000);
    check_eq("reset_wen", 32'(debug_wb_rf_wen), 32'h0);
    check_eq("reset_wdata", wb_wdata, 32'h0);
    check_all();

    // ALU write
    drive_mem(1, 32'h100, 1, 5'd5, 32'h1234_5678, 0, 0, 0);
    tick();
    drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("alu_wreg", 32'(wb_wreg), 32'h1);
    check_eq("alu_waddr", 32'(wb_waddr), 32'd5);
    check_eq("alu_wdata", wb_wdata, 32'h1234_5678);
    check_eq("alu_wen", 32'(debug_wb_rf_wen), 32'hF);
    check_all();
    tick();

    // Load alignment
    for (int i = 0; i < 5; i++) begin
      drive_mem(1, 32'h200 + 32'(4 * i), 1, 5'd8, 32'h0, 1, al_op[i], al_lo[i]);
      tick();
      drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
      data_sram_rdata = 32'h80FF_7F01;
      #1;
      check_eq("align", wb_wdata, al_exp[i]);
      check_all();
    end
    tick();

    // Stalled load keeps its first-cycle data
    drive_mem(1, 32'h300, 1, 5'd9, 32'h0, 1, 3'd4, 2'd0);
    tick();
    drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1; data_sram_rdata = 32'hCAFE_BABE;
    #1;
    check_eq("stall_ld0", wb_wdata, 32'hCAFE_BABE);
    check_all();
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hDEAD_0000;
      #1;
      check_eq("stall_ldN", wb_wdata, 32'hCAFE_BABE);
      check_eq("stall_we", 32'(wb_wreg), 32'h1);
      check_all();
    end
    stall = 0;
    tick();

    // Flush during stall
    drive_mem(1, 32'h400, 1, 5'd10, 32'hAAAA_5555, 0, 0, 0);
    tick();
    drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1;
    #1; check_all();
    tick();
    flush = 1;
    #1; check_eq("pre_flush_we", 32'(wb_wreg), 32'h1); check_all();
    tick();
    stall = 0; flush = 0;
    #1; check_eq("flush_we", 32'(wb_wreg), 32'h0); check_all();

    // Back-to-back loads, no stall
    drive_mem(1, 32'h500, 1, 5'd11, 32'h0, 1, 3'd4, 2'd0);
    tick();
    drive_mem(1, 32'h504, 1, 5'd12, 32'h0, 1, 3'd1, 2'd0);
    data_sram_rdata = 32'h1111_2222;
    #1; check_eq("b2b_0", wb_wdata, 32'h1111_2222); check_all();
    tick();
    drive_mem(0, 0, 0, 0, 0, 0, 0, 0);
    data_sram_rdata = 32'h3333_44AB;
    #1; check_eq("b2b_1", wb_wdata, 32'h0000_00AB); check_all();
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 35);
      drive_mem(1'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
                1'($urandom), 3'($urandom), 2'($urandom));
      data_sram_rdata = $urandom;
      #1; check_all();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
